fb_scanout: RTL and testbench
=============================

# fb_scanout

Read side of the game's 320x240 8-bit palette framebuffer. Walks the frame memory in step with the 640x480 VGA raster and replicates each stored pixel 2x2. Delivers palette indices to `palette_mapper`. Owns the double-buffer swap handshake with `drawing_engine`, which always writes the buffer that is not being displayed.

## Interface
Parameters:
- W, 320, framebuffer width in pixels
- H, 240, framebuffer height in pixels
- DW, 8, palette index width
- AW, 17, frame memory word address width (per buffer)

Ports:
- Clk  in  1  50 MHz system clock, shared with the VGA controller
- Reset  in  1  synchronous, active-high reset
- pixel_en  in  1  one-cycle strobe per 25 MHz pixel; DrawX/DrawY are valid on this cycle
- DrawX  in  10  raster column from vga_controller, 0..799
- DrawY  in  10  raster row from vga_controller, 0..524
- swap_req  in  1  one-cycle pulse from drawing_engine: back buffer is complete
- swap_ack  out  1  one-cycle pulse: the swap has been applied
- buffer_using  out  1  buffer currently displayed; the drawer writes ~buffer_using
- rd_en  out  1  frame memory read strobe
- rd_addr  out  AW  word address within the selected buffer
- rd_buf  out  1  buffer select for the read, equal to buffer_using
- rd_data  in  DW  memory read data, valid 1 Clk after rd_en
- pix_out  out  DW  palette index to palette_mapper
- pix_valid  out  1  pix_out belongs to the visible area

## Operation
- **Visible area:** DrawX<2W and DrawY<2H. The source pixel is (DrawX>>1, DrawY>>1).
- **Address generation:** no multiplier.
  - line_base register: cleared when DrawY==0, incremented by W after the last visible pixel of each odd row.
  - rd_addr = line_base + (DrawX>>1).
  - The maximum address is W*H-1 = 76799. No address at or above W*H is ever issued.
- **Memory reads:** on a pixel_en cycle in the visible area, rd_en=1 and rd_addr/rd_buf are registered.
  - Outside the visible area, rd_en=0 and rd_addr holds its last value.
- **Output pipeline:** a valid bit travels with each read.
  - pix_out/pix_valid are loaded from rd_data when the valid bit returns.
  - On a non-visible pixel_en, pix_out=0 and pix_valid=0.
- **Frame end (fe):** pixel_en && DrawX==0 && DrawY==2H (start of vertical blank).
- **Swap FSM:** states IDLE and PENDING.
  - IDLE, swap_req=1 → PENDING.
  - PENDING, fe → toggle buffer_using, pulse swap_ack for 1 cycle, → IDLE.
  - swap_req while in PENDING is absorbed. No second swap and no second ack occur.
  - swap_req in IDLE on the same cycle as fe → PENDING. The swap happens at the following fe and never mid-frame.
  - A swap never occurs outside fe, so a displayed frame is never torn.
- **Reset values:** buffer_using=0, swap_ack=0, rd_en=0, rd_addr=0, rd_buf=0, pix_out=0, pix_valid=0, FSM=IDLE, line_base=0, pipeline valid bits=0.
  - Reset asserted mid-frame drops any pending swap. Scanout resumes correctly on the next DrawY==0.

## Timing
- Cycle T (pixel_en=1) samples DrawX/DrawY.
- T+1: rd_en, rd_addr, rd_buf registered.
- T+2: rd_data valid.
- T+3: pix_out/pix_valid registered.
- Fixed latency is 3 Clk from the pixel_en sample to pix_out. The top level delays hs/vs to match.
- swap_ack is asserted on the Clk edge after the fe cycle. buffer_using changes on the same edge.
- The drawer may start writing the new back buffer on the cycle after swap_ack.
- Arithmetic: line_base and rd_addr are AW bits unsigned. DrawX>>1 is zero-extended.

## Configuration
- FB_SCANOUT_DOUBLE_BUFFER_EN defined: behaviour exactly as above.
- Undefined: single-buffer build.
  - buffer_using and rd_buf are tied to 0.
  - The FSM is removed.
  - swap_ack is swap_req delayed by one register (ack 1 cycle after request, regardless of raster position).
  - All scanout behaviour is otherwise identical.

## Structure
- Shared package fb_pkg holds:
  - FB_W=320, FB_H=240, FB_DW=8, FB_AW=17
  - typedef fb_addr_t (logic [FB_AW-1:0]) and fb_pix_t (logic [FB_DW-1:0])
  - swap FSM enum swap_state_t {SW_IDLE, SW_PENDING}
- These constants are shared with framebuffer2 and drawing_engine.
- Sub-module fb_addr_gen holds line_base, the visible-area decode and rd_addr/rd_en registration. fb_scanout holds the swap FSM and the output pipeline.

## Test plan
- Full frame, memory preloaded with addr[7:0] → at raster (DrawX=2, DrawY=1), pix_out=1 after 3 Clk. At (639,479), rd_addr=76799 and pix_out=0xFF. rd_en never asserted outside 640x480.
- Row replication → DrawY=0 and DrawY=1 issue identical address sequences 0..319. DrawY=2 starts at 320.
- swap_req pulse at DrawY=100 → buffer_using unchanged until fe. swap_ack is exactly one pulse the cycle after fe. buffer_using=1 from then on.
- Three swap_req pulses within one frame → exactly one toggle and one swap_ack at the next fe.
- swap_req on the same cycle as fe → no swap at that fe. Swap and ack occur at the following fe (one frame later).
- Reset asserted in PENDING mid-frame → buffer_using=0, no swap_ack at the next fe. pix_out=0 and pix_valid=0 until the first visible pixel after DrawY wraps to 0.

Source files
------------

// File: rtl/fb_pkg.sv
// Framebuffer constants and types shared by the scanout, framebuffer2 and drawing_engine.
package fb_pkg;
   localparam int unsigned FB_W  = 320;
   localparam int unsigned FB_H  = 240;
   localparam int unsigned FB_DW = 8;
   localparam int unsigned FB_AW = 17;

   typedef logic [FB_AW-1:0] fb_addr_t;
   typedef logic [FB_DW-1:0] fb_pix_t;

   typedef enum logic {SW_IDLE, SW_PENDING} swap_state_t;
endpackage

// File: rtl/fb_scanout_if.sv
// Frame memory read bus between fb_scanout (master) and the framebuffer (slave).
interface fb_scanout_if #(
   parameter int AW = 17,
   parameter int DW = 8
);
   logic          rd_en;
   logic [AW-1:0] rd_addr;
   logic          rd_buf;
   logic [DW-1:0] rd_data;

   modport master (output rd_en, output rd_addr, output rd_buf, input rd_data);
   modport slave  (input rd_en, input rd_addr, input rd_buf, output rd_data);
endinterface

// File: rtl/fb_addr_gen.sv
// Visible-area decode and multiplier-free read address generation with 2x2 pixel replication.
module fb_addr_gen
   import fb_pkg::*;
#(
   parameter int W  = FB_W,
   parameter int H  = FB_H,
   parameter int AW = FB_AW
) (
   input  logic          Clk,
   input  logic          Reset,
   input  logic          i_pixel_en,
   input  logic [9:0]    i_x,
   input  logic [9:0]    i_y,
   input  logic          i_buf,
   output logic          o_rd_en,
   output logic [AW-1:0] o_rd_addr,
   output logic          o_rd_buf,
   output logic          o_blank
);

   logic [AW-1:0] r_line_base;
   logic          r_sync;
   logic          w_row0;
   logic          w_area;
   logic          w_vis;
   logic          w_last;
   logic [AW-1:0] w_base;
   logic [AW-1:0] w_addr;

   // Reads are suppressed after reset until the raster reaches row 0, so a
   // mid-frame reset cannot fetch from a line_base that is out of step.
   always_comb begin
      w_row0 = (i_y == 10'd0);
      w_area = (i_x < 10'(2*W)) && (i_y < 10'(2*H));
      w_vis  = w_area && (r_sync || w_row0);
      w_base = w_row0 ? '0 : r_line_base;
      w_addr = w_base + AW'(i_x[9:1]);
      w_last = w_vis && (i_x == 10'(2*W-1)) && i_y[0];
   end

   always_ff @(posedge Clk) begin
      if (Reset) begin
         r_line_base <= '0;
         r_sync      <= 1'b0;
         o_rd_en     <= 1'b0;
         o_rd_addr   <= '0;
         o_rd_buf    <= 1'b0;
         o_blank     <= 1'b0;
      end else begin
         o_rd_en <= i_pixel_en && w_vis;
         o_blank <= i_pixel_en && !w_vis;
         if (i_pixel_en && w_row0)
            r_sync <= 1'b1;
         if (i_pixel_en && w_vis) begin
            o_rd_addr <= w_addr;
            o_rd_buf  <= i_buf;
         end
         if (i_pixel_en) begin
            if (w_last)
               r_line_base <= w_base + AW'(W);
            else if (w_row0)
               r_line_base <= '0;
         end
      end
   end

endmodule

// File: rtl/fb_scanout.sv
// Framebuffer scanout: 3-cycle read pipeline plus front/back buffer swap at frame end.
// FB_SCANOUT_DOUBLE_BUFFER_EN enables the swap FSM; otherwise a single buffer is used.
module fb_scanout
   import fb_pkg::*;
#(
   parameter int W  = FB_W,
   parameter int H  = FB_H,
   parameter int DW = FB_DW,
   parameter int AW = FB_AW
) (
   input  logic          Clk,
   input  logic          Reset,
   input  logic          pixel_en,
   input  logic [9:0]    DrawX,
   input  logic [9:0]    DrawY,
   input  logic          swap_req,
   output logic          swap_ack,
   output logic          buffer_using,
   fb_scanout_if.master  mem,
   output logic [DW-1:0] pix_out,
   output logic          pix_valid
);

   logic          w_rd_en;
   logic [AW-1:0] w_rd_addr;
   logic          w_rd_buf;
   logic          w_blank;
   logic          r_vld2;
   logic          r_blk2;

   fb_addr_gen #(.W(W), .H(H), .AW(AW)) u_addr_gen (
      .Clk        (Clk),
      .Reset      (Reset),
      .i_pixel_en (pixel_en),
      .i_x        (DrawX),
      .i_y        (DrawY),
      .i_buf      (buffer_using),
      .o_rd_en    (w_rd_en),
      .o_rd_addr  (w_rd_addr),
      .o_rd_buf   (w_rd_buf),
      .o_blank    (w_blank)
   );

   assign mem.rd_en   = w_rd_en;
   assign mem.rd_addr = w_rd_addr;
   assign mem.rd_buf  = w_rd_buf;

   // The blank marker travels alongside the read valid so blanking keeps the same latency.
   always_ff @(posedge Clk) begin
      if (Reset) begin
         r_vld2    <= 1'b0;
         r_blk2    <= 1'b0;
         pix_out   <= '0;
         pix_valid <= 1'b0;
      end else begin
         r_vld2 <= w_rd_en;
         r_blk2 <= w_blank;
         if (r_vld2) begin
            pix_out   <= mem.rd_data;
            pix_valid <= 1'b1;
         end else if (r_blk2) begin
            pix_out   <= '0;
            pix_valid <= 1'b0;
         end
      end
   end

`ifdef FB_SCANOUT_DOUBLE_BUFFER_EN
   swap_state_t r_state;
   swap_state_t w_next;
   logic        w_fe;
   logic        w_swap;

   always_comb begin
      w_fe   = pixel_en && (DrawX == 10'd0) && (DrawY == 10'(2*H));
      w_next = r_state;
      w_swap = 1'b0;
      case (r_state)
         SW_IDLE:    if (swap_req) w_next = SW_PENDING;
         SW_PENDING: if (w_fe) begin
            w_swap = 1'b1;
            w_next = SW_IDLE;
         end
         default:    w_next = SW_IDLE;
      endcase
   end

   always_ff @(posedge Clk) begin
      if (Reset) begin
         r_state      <= SW_IDLE;
         swap_ack     <= 1'b0;
         buffer_using <= 1'b0;
      end else begin
         r_state  <= w_next;
         swap_ack <= w_swap;
         if (w_swap)
            buffer_using <= ~buffer_using;
      end
   end
`else
   assign buffer_using = 1'b0;

   always_ff @(posedge Clk) begin
      if (Reset)
         swap_ack <= 1'b0;
      else
         swap_ack <= swap_req;
   end
`endif

endmodule

// File: tb/tb_fb_scanout.sv
// Scoreboard bench for fb_scanout on a compressed raster (blank regions sparsely sampled).
module tb_fb_scanout;
   import fb_pkg::*;

`ifdef FB_SCANOUT_DOUBLE_BUFFER_EN
   localparam bit DB = 1'b1;
`else
   localparam bit DB = 1'b0;
`endif

   logic       Clk = 1'b0;
   logic       Reset;
   logic       pixel_en;
   logic [9:0] DrawX;
   logic [9:0] DrawY;
   logic       swap_req;
   logic       swap_ack;
   logic       buffer_using;
   logic [7:0] pix_out;
   logic       pix_valid;

   fb_scanout_if #(.AW(17), .DW(8)) mem ();

   fb_scanout #(.W(320), .H(240), .DW(8), .AW(17)) dut (
      .Clk          (Clk),
      .Reset        (Reset),
      .pixel_en     (pixel_en),
      .DrawX        (DrawX),
      .DrawY        (DrawY),
      .swap_req     (swap_req),
      .swap_ack     (swap_ack),
      .buffer_using (buffer_using),
      .mem          (mem),
      .pix_out      (pix_out),
      .pix_valid    (pix_valid)
   );

   always #10 Clk = ~Clk;

   // Frame memory model: buffer 0 holds addr[7:0], buffer 1 its complement.
   always @(posedge Clk)
      if (mem.rd_en)
         mem.rd_data <= mem.rd_buf ? ~mem.rd_addr[7:0] : mem.rd_addr[7:0];

   typedef struct {
      bit         vis;
      logic [16:0] addr;
      bit         bufs;
      logic [7:0] data;
   } exp_t;

   exp_t q_rd[$];
   exp_t q_pix[$];
   int   n_cmp = 0;
   int   n_bad = 0;
   bit   m_sync = 0, m_pend = 0, m_buf = 0;
   int   m_ack = 0, ack_cnt = 0;
   bit   pe_d1 = 0, pe_d2 = 0;
   bit   req_row [525];

   // Checker: read bus 1 clk after a sampled pixel_en, pixel output 3 clk after.
   always @(posedge Clk) begin
      bit   pe0;
      exp_t it;
      pe0 = pixel_en;
      if (Reset) begin
         q_rd.delete();
         q_pix.delete();
         pe_d1 = 0;
         pe_d2 = 0;
      end else begin
         #1;
         if (swap_ack) ack_cnt++;
         n_cmp++;
         if (pe0) begin
            if (q_rd.size() == 0) begin
               n_bad++;
               $display("FAIL rd_queue got=empty exp=entry");
            end else begin
               it = q_rd.pop_front();
               if (mem.rd_en !== it.vis) begin
                  n_bad++;
                  $display("FAIL rd_en got=%b exp=%b", mem.rd_en, it.vis);
               end else if (it.vis && (mem.rd_addr !== it.addr || mem.rd_buf !== it.bufs)) begin
                  n_bad++;
                  $display("FAIL rd_addr got=%0d/%b exp=%0d/%b", mem.rd_addr, mem.rd_buf, it.addr, it.bufs);
               end
               q_pix.push_back(it);
            end
         end else if (mem.rd_en !== 1'b0) begin
            n_bad++;
            $display("FAIL rd_en_stray got=%b exp=0", mem.rd_en);
         end
         if (pe_d2) begin
            n_cmp++;
            if (q_pix.size() == 0) begin
               n_bad++;
               $display("FAIL pix_queue got=empty exp=entry");
            end else begin
               it = q_pix.pop_front();
               if (pix_valid !== it.vis || pix_out !== it.data) begin
                  n_bad++;
                  $display("FAIL pix_out got=%h/%b exp=%h/%b", pix_out, pix_valid, it.data, it.vis);
               end
            end
         end
         pe_d2 = pe_d1;
         pe_d1 = pe0;
      end
   end

   task automatic drive_pixel(input int x, input int y, input bit req);
      exp_t it;
      bit   fe, eack;
      @(negedge Clk);
      if (y == 0) m_sync = 1;
      it.vis  = (x < 640) && (y < 480) && m_sync;
      it.addr = 17'((y / 2) * 320 + x / 2);
      it.bufs = m_buf;
      it.data = it.vis ? (m_buf ? ~it.addr[7:0] : it.addr[7:0]) : 8'h00;
      q_rd.push_back(it);
      fe = (x == 0) && (y == 480);
      if (DB) begin
         eack = m_pend && fe;
         if (eack) begin
            m_buf  = !m_buf;
            m_pend = 0;
         end else if (req) begin
            m_pend = 1;
         end
      end else begin
         eack = req;
      end
      if (eack) m_ack++;
      pixel_en = 1'b1;
      DrawX    = 10'(x);
      DrawY    = 10'(y);
      swap_req = req;
      @(negedge Clk);
      pixel_en = 1'b0;
      swap_req = 1'b0;
      n_cmp++;
      if (swap_ack !== eack) begin
         n_bad++;
         $display("FAIL swap_ack at (%0d,%0d) got=%b exp=%b", x, y, swap_ack, eack);
      end
      n_cmp++;
      if (buffer_using !== m_buf) begin
         n_bad++;
         $display("FAIL buffer_using at (%0d,%0d) got=%b exp=%b", x, y, buffer_using, m_buf);
      end
   endtask

   task automatic run_rows(input int y0, input int y1, input bit full3);
      for (int y = y0; y <= y1; y++) begin
         bit r = req_row[y];
         if (y < 480) begin
            if (full3 && y < 3) begin
               for (int x = 0; x < 640; x++) drive_pixel(x, y, r && x == 0);
            end else begin
               drive_pixel(0, y, r);
               drive_pixel(1, y, 1'b0);
               drive_pixel(2, y, 1'b0);
               drive_pixel(638, y, 1'b0);
               drive_pixel(639, y, 1'b0);
            end
            drive_pixel(700, y, 1'b0);
         end else if (y == 480 || y == 524) begin
            drive_pixel(0, y, r);
            drive_pixel(700, y, 1'b0);
         end
      end
   endtask

   task automatic test_reset();
      Reset = 1'b1; pixel_en = 1'b0; swap_req = 1'b0; DrawX = '0; DrawY = '0;
      repeat (3) @(negedge Clk);
      n_cmp++;
      if (swap_ack !== 1'b0 || buffer_using !== 1'b0 || mem.rd_en !== 1'b0 ||
          mem.rd_addr !== 17'd0 || mem.rd_buf !== 1'b0 || pix_out !== 8'h00 || pix_valid !== 1'b0) begin
         n_bad++;
         $display("FAIL reset_state got=%b%b%b%0d%b%h%b exp=000000000",
                  swap_ack, buffer_using, mem.rd_en, mem.rd_addr, mem.rd_buf, pix_out, pix_valid);
      end
      Reset = 1'b0;
   endtask

   task automatic test_row_replication();
      run_rows(0, 0, 1'b1);
      drive_pixel(0, 1, 1'b0);
      drive_pixel(1, 1, 1'b0);
      drive_pixel(2, 1, 1'b0);
      drive_pixel(3, 1, 1'b0);
      n_cmp++;
      if (pix_out !== 8'h01 || pix_valid !== 1'b1) begin
         n_bad++;
         $display("FAIL pix_2_1 got=%h/%b exp=01/1", pix_out, pix_valid);
      end
      for (int x = 4; x < 640; x++) drive_pixel(x, 1, 1'b0);
      drive_pixel(700, 1, 1'b0);
      drive_pixel(0, 2, 1'b0);
      n_cmp++;
      if (mem.rd_addr !== 17'd320 || mem.rd_en !== 1'b1) begin
         n_bad++;
         $display("FAIL row2_base got=%0d/%b exp=320/1", mem.rd_addr, mem.rd_en);
      end
   endtask

   task automatic test_full_frame();
      for (int x = 1; x < 640; x++) drive_pixel(x, 2, 1'b0);
      drive_pixel(700, 2, 1'b0);
      run_rows(3, 478, 1'b0);
      drive_pixel(0, 479, 1'b0);
      drive_pixel(638, 479, 1'b0);
      drive_pixel(639, 479, 1'b0);
      n_cmp++;
      if (mem.rd_addr !== 17'd76799 || mem.rd_en !== 1'b1) begin
         n_bad++;
         $display("FAIL last_addr got=%0d/%b exp=76799/1", mem.rd_addr, mem.rd_en);
      end
      drive_pixel(700, 479, 1'b0);
      n_cmp++;
      if (pix_out !== 8'hFF || pix_valid !== 1'b1) begin
         n_bad++;
         $display("FAIL last_pix got=%h/%b exp=ff/1", pix_out, pix_valid);
      end
      run_rows(480, 524, 1'b0);
   endtask

   task automatic test_swap();
      int a0;
      a0 = ack_cnt;
      req_row[100] = 1;
      run_rows(0, 479, 1'b0);
      req_row[100] = 0;
      n_cmp++;
      if (ack_cnt !== a0 + (DB ? 0 : 1) || buffer_using !== 1'b0) begin
         n_bad++;
         $display("FAIL swap_before_fe got=%0d/%b exp=%0d/0", ack_cnt - a0, buffer_using, DB ? 0 : 1);
      end
      run_rows(480, 524, 1'b0);
      n_cmp++;
      if (ack_cnt !== a0 + 1 || buffer_using !== DB) begin
         n_bad++;
         $display("FAIL swap_after_fe got=%0d/%b exp=1/%b", ack_cnt - a0, buffer_using, DB);
      end
   endtask

   task automatic test_triple_req();
      int a0;
      a0 = ack_cnt;
      req_row[50] = 1; req_row[150] = 1; req_row[250] = 1;
      run_rows(0, 524, 1'b0);
      req_row[50] = 0; req_row[150] = 0; req_row[250] = 0;
      n_cmp++;
      if (ack_cnt !== a0 + (DB ? 1 : 3) || buffer_using !== 1'b0) begin
         n_bad++;
         $display("FAIL triple_req got=%0d/%b exp=%0d/0", ack_cnt - a0, buffer_using, DB ? 1 : 3);
      end
   endtask

   task automatic test_req_at_fe();
      int a0;
      a0 = ack_cnt;
      req_row[480] = 1;
      run_rows(0, 524, 1'b0);
      req_row[480] = 0;
      n_cmp++;
      if (ack_cnt !== a0 + (DB ? 0 : 1) || buffer_using !== 1'b0) begin
         n_bad++;
         $display("FAIL req_at_fe_first got=%0d/%b exp=%0d/0", ack_cnt - a0, buffer_using, DB ? 0 : 1);
      end
      run_rows(0, 524, 1'b0);
      n_cmp++;
      if (ack_cnt !== a0 + 1 || buffer_using !== DB) begin
         n_bad++;
         $display("FAIL req_at_fe_next got=%0d/%b exp=1/%b", ack_cnt - a0, buffer_using, DB);
      end
   endtask

   task automatic test_reset_pending();
      int a0;
      req_row[100] = 1;
      run_rows(0, 200, 1'b0);
      req_row[100] = 0;
      Reset = 1'b1;
      repeat (3) @(negedge Clk);
      Reset  = 1'b0;
      m_pend = 0; m_buf = 0; m_sync = 0;
      n_cmp++;
      if (buffer_using !== 1'b0 || swap_ack !== 1'b0 || pix_out !== 8'h00 || pix_valid !== 1'b0) begin
         n_bad++;
         $display("FAIL mid_reset got=%b%b%h%b exp=00000", buffer_using, swap_ack, pix_out, pix_valid);
      end
      a0 = ack_cnt;
      run_rows(201, 524, 1'b0);
      n_cmp++;
      if (ack_cnt !== a0 || buffer_using !== 1'b0) begin
         n_bad++;
         $display("FAIL dropped_swap got=%0d/%b exp=0/0", ack_cnt - a0, buffer_using);
      end
      run_rows(0, 10, 1'b0);
      repeat (4) @(negedge Clk);
      n_cmp++;
      if (ack_cnt !== m_ack || q_rd.size() != 0 || q_pix.size() != 0) begin
         n_bad++;
         $display("FAIL drain got=%0d/%0d/%0d exp=%0d/0/0", ack_cnt, q_rd.size(), q_pix.size(), m_ack);
      end
   endtask

   initial begin
      #10ms;
      $display("FAIL timeout got=running exp=finished");
      $fatal(1, "timeout");
   end

   initial begin
      test_reset();
      test_row_replication();
      test_full_frame();
      test_swap();
      test_triple_req();
      test_req_at_fe();
      test_reset_pending();
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
